// File: rtl/route_stage_locked_if.sv
// rtl/route_stage_locked_if.sv - flit stream bundle for the route stage; also holds the params_noc direction enum
//
// params_noc::inout_Port : next-hop direction (LOCAL/NORTH/SOUTH/EAST/WEST)
// route_stage_locked_if  : input side  in_valid/in_ready/in_flit/in_type/in_x_Dest/in_y_Dest
//                          output side out_valid/out_ready/out_flit/out_type/out_port
//   modport slave  : the route stage (consumes in_*, produces out_*)
//   modport master : the environment driving the stage

package params_noc;
    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } inout_Port;
endpackage

interface route_stage_locked_if #(
    parameter int FLIT_W  = 32,
    parameter int COORD_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_W-1:0]     in_flit;
    logic [1:0]            in_type;
    logic [COORD_W-1:0]    in_x_Dest;
    logic [COORD_W-1:0]    in_y_Dest;
    logic                  out_valid;
    logic                  out_ready;
    logic [FLIT_W-1:0]     out_flit;
    logic [1:0]            out_type;
    params_noc::inout_Port out_port;

    modport slave (
        input  in_valid, in_flit, in_type, in_x_Dest, in_y_Dest, out_ready,
        output in_ready, out_valid, out_flit, out_type, out_port
    );

    modport master (
        output in_valid, in_flit, in_type, in_x_Dest, in_y_Dest, out_ready,
        input  in_ready, out_valid, out_flit, out_type, out_port
    );
endinterface

// File: rtl/route_stage_locked.sv
// rtl/route_stage_locked.sv - registered packet-aware dimension-order route stage with route lock
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : route_stage_locked_if.slave (input flit stream in, routed flit stream out)
//   err       : sticky protocol/address error flag
//   pkt_count : per-direction head counters, present only when ROUTE_STATS_EN is defined
//
// Optional feature macro: ROUTE_STATS_EN

module route_stage_locked
    import params_noc::*;
#(
    parameter int x_Current = 0,
    parameter int y_Current = 0,
    parameter int MESH_X    = 4,
    parameter int MESH_Y    = 4,
    parameter int COORD_W   = 4,
    parameter int FLIT_W    = 32,
    parameter int YX_MODE   = 0
) (
    input  logic clk,
    input  logic rst,
    route_stage_locked_if.slave bus,
    output logic err
`ifdef ROUTE_STATS_EN
    ,
    output logic [15:0] pkt_count [5]
`endif
);

    localparam logic [1:0] T_HEAD = 2'b00;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_HT   = 2'b11;

    // Coordinates and mesh bounds widened by one bit so offsets cannot wrap.
    localparam logic [COORD_W:0] XC = (COORD_W+1)'(x_Current);
    localparam logic [COORD_W:0] YC = (COORD_W+1)'(y_Current);
    localparam logic [COORD_W:0] MX = (COORD_W+1)'(MESH_X);
    localparam logic [COORD_W:0] MY = (COORD_W+1)'(MESH_Y);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t            state_q, state_d;
    inout_Port         locked_q, locked_d;
    logic              valid_q, valid_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic [1:0]        type_q, type_d;
    inout_Port         port_q, port_d;
    logic              err_q, err_d;

    logic              accept;
    logic              is_head;
    logic              out_of_range;
    logic [COORD_W:0]  dx, dy;
    logic              dx_neg, dx_pos, dy_neg, dy_pos;
    inout_Port         x_dir, y_dir, calc_route, head_route;

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = valid_q;
    assign bus.out_flit  = flit_q;
    assign bus.out_type  = type_q;
    assign bus.out_port  = port_q;
    assign err           = err_q;

    // HEAD (00) and HEADTAIL (11) are the two types with equal bits.
    assign is_head = (bus.in_type[1] == bus.in_type[0]);

    // Route computation for a head flit.
    always_comb begin
        dx           = {1'b0, bus.in_x_Dest} - XC;
        dy           = {1'b0, bus.in_y_Dest} - YC;
        dx_neg       = dx[COORD_W];
        dy_neg       = dy[COORD_W];
        dx_pos       = !dx_neg && (dx != '0);
        dy_pos       = !dy_neg && (dy != '0);
        x_dir        = dx_neg ? WEST  : (dx_pos ? EAST  : LOCAL);
        y_dir        = dy_neg ? NORTH : (dy_pos ? SOUTH : LOCAL);
        out_of_range = ({1'b0, bus.in_x_Dest} >= MX) || ({1'b0, bus.in_y_Dest} >= MY);
        if (YX_MODE != 0) begin
            calc_route = (y_dir != LOCAL) ? y_dir : x_dir;
        end else begin
            calc_route = (x_dir != LOCAL) ? x_dir : y_dir;
        end
        head_route = out_of_range ? LOCAL : calc_route;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            locked_q <= LOCAL;
            valid_q  <= 1'b0;
            flit_q   <= '0;
            type_q   <= 2'b00;
            port_q   <= LOCAL;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            locked_q <= locked_d;
            valid_q  <= valid_d;
            flit_q   <= flit_d;
            type_q   <= type_d;
            port_q   <= port_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        locked_d = locked_q;
        valid_d  = valid_q;
        flit_d   = flit_q;
        type_d   = type_q;
        port_d   = port_q;
        err_d    = err_q;

        // The held flit leaves first; an accepted flit may refill the slot below.
        if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            if (is_head) begin
                // A head arriving inside an open packet is flagged but still
                // starts a new packet, so the stage resynchronises on it.
                if (out_of_range || state_q == LOCKED) begin
                    err_d = 1'b1;
                end
                locked_d = head_route;
                valid_d  = 1'b1;
                flit_d   = bus.in_flit;
                type_d   = bus.in_type;
                port_d   = head_route;
                state_d  = (bus.in_type == T_HEAD) ? LOCKED : IDLE;
            end else if (state_q == IDLE) begin
                // Orphan BODY/TAIL: swallowed without producing output.
                err_d = 1'b1;
            end else begin
                valid_d = 1'b1;
                flit_d  = bus.in_flit;
                type_d  = bus.in_type;
                port_d  = locked_q;
                if (bus.in_type == T_TAIL) begin
                    state_d = IDLE;
                end
            end
        end
    end

`ifdef ROUTE_STATS_EN
    logic out_fire_head;
    assign out_fire_head = valid_q && bus.out_ready &&
                           (type_q == T_HEAD || type_q == T_HT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 5; i++) begin
                pkt_count[i] <= '0;
            end
        end else if (out_fire_head) begin
            pkt_count[port_q] <= pkt_count[port_q] + 16'd1;
        end
    end
`endif

endmodule

// File: doc/route_stage_locked.md
Name: route_stage_locked

Overview:
- Registered, packet-aware route computation stage; one instance per router input port, between the input buffer and the switch allocator.
- Computes the next-hop direction from the head-flit destination using dimension-order routing, selectable XY or YX.
- Locks that direction for the body and tail flits of the same packet, and releases it on the tail.
- Single-entry output register with valid/ready handshake; adds an error flag, which the previous generation lacked.

Parameters:
- x_Current, 0, X coordinate of this router.
- y_Current, 0, Y coordinate of this router.
- MESH_X, 4, mesh width; valid X destinations are 0..MESH_X-1.
- MESH_Y, 4, mesh height; valid Y destinations are 0..MESH_Y-1.
- COORD_W, 4, width of the destination coordinate fields.
- FLIT_W, 32, width of the flit payload passed through.
- YX_MODE, 0, routing order: 0 = XY (resolve X first), 1 = YX (resolve Y first).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input flit valid.
- in_ready  out  1  stage can accept a flit this cycle.
- in_flit  in  FLIT_W  flit payload.
- in_type  in  2  flit type: 00 HEAD, 01 BODY, 10 TAIL, 11 HEADTAIL (single-flit packet).
- in_x_Dest  in  COORD_W  destination X; sampled only on HEAD/HEADTAIL.
- in_y_Dest  in  COORD_W  destination Y; sampled only on HEAD/HEADTAIL.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts the output flit.
- out_flit  out  FLIT_W  registered payload.
- out_type  out  2  registered flit type.
- out_port  out  inout_Port  next-hop direction (params_noc enum: LOCAL/NORTH/SOUTH/EAST/WEST).
- err  out  1  sticky protocol/address error flag.

Behaviour:
- Reset values: out_valid=0, out_flit=0, out_type=00, out_port=LOCAL, err=0, FSM=IDLE, locked route=LOCAL.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer happens when in_valid && in_ready.
  - Output holds stable while out_valid && !out_ready.
- Latency: 1 cycle. A flit accepted in cycle N appears on out_* in cycle N+1. Full throughput of 1 flit/cycle when out_ready stays high.
- Offsets:
  - dx = in_x_Dest - x_Current and dy = in_y_Dest - y_Current.
  - Both are computed signed at COORD_W+1 bits (zero-extended operands) so that no wrap can occur.
- Direction rules:
  - dx<0 → WEST, dx>0 → EAST, dy<0 → NORTH, dy>0 → SOUTH, both 0 → LOCAL.
  - XY order: check X first, then Y.
  - YX order: check Y first, then X.
- FSM states: IDLE (no packet open), LOCKED (packet open).
  - IDLE + HEAD accepted → compute route, store as locked route, go to LOCKED.
  - IDLE + HEADTAIL accepted → compute route, stay IDLE.
  - IDLE + BODY/TAIL accepted → flit consumed but not forwarded (out_valid unchanged); set err.
  - LOCKED + BODY accepted → forward with locked route.
  - LOCKED + TAIL accepted → forward with locked route, go to IDLE.
  - LOCKED + HEAD/HEADTAIL accepted → set err and treat as a fresh head: recompute route; next state LOCKED for HEAD, IDLE for HEADTAIL.
- Out-of-range destination (in_x_Dest>=MESH_X or in_y_Dest>=MESH_Y) on a head: route forced to LOCAL, err set, packet otherwise handled normally.
- err is sticky; only rst clears it.
- Reset mid-packet: FSM returns to IDLE and out_valid drops next cycle. Any following BODY/TAIL is then an error as above.
- No flit is dropped or duplicated under backpressure. A stalled out_* register is not overwritten.

Optional Feature:
- Macro: ROUTE_STATS_EN.
- When defined, adds output port pkt_count [5][16] (one counter per inout_Port value):
  - Increments the counter of out_port on each output transfer (out_valid && out_ready) of a HEAD or HEADTAIL flit.
  - Counters wrap at 16 bits and are cleared by rst.
- When not defined, the port and counters are absent; all other behaviour is identical.

Test Plan:
- Router (1,1), XY, out_ready=1: HEAD dest (3,0), BODY, TAIL on consecutive cycles → out_port=EAST for all three, each one cycle late; FSM ends IDLE; err=0.
- Router (1,1), YX_MODE=1: HEADTAIL dest (3,0) → out_port=NORTH; dest (1,1) → LOCAL; dest (0,2) → SOUTH.
- Backpressure: out_ready=0 for 3 cycles after HEAD dest (0,1) is accepted → in_ready=0, out_flit/out_port=WEST held stable; release → next flit accepted that cycle.
- Router (0,0), MESH_X=4, COORD_W=4: HEAD dest (15,0) → out_port=LOCAL, err=1; dest (3,0) → EAST with no wrap (verifies widened offset).
- Protocol: BODY while IDLE → no output, err=1; then HEAD, BODY, rst asserted, TAIL → output stops after rst, TAIL not forwarded.
- ROUTE_STATS_EN: 2 EAST packets and 1 LOCAL HEADTAIL → pkt_count[EAST]=2, pkt_count[LOCAL]=1, others 0; rst → all 0.
